freg_restore_seq: RTL
=====================

// Module: freg_restore_seq
// PURPOSE
//  Restore-side sequencer for the F-register backup stack. On a restore request it
//  pulses the stack's restore input and captures the 256-bit snapshot the stack returns.
//  It then writes the snapshot back into the F register file, one register per cycle.
//  It tracks stack depth from backup/restore traffic and refuses restores on an empty stack.
// PARAMETERS
//  REG_W     16  width of one F register
//  NUM_REGS  16  registers per snapshot; snapshot width = REG_W*NUM_REGS (256)
//  READ_LAT  1   cycles from the fbs_restore-high cycle to fbs_data valid (>=1)
//  DEPTH_W   16  width of the depth counter (matches the stack pointer width)
// PORTS
//  clk          in   1                rising-edge clock
//  reset        in   1                synchronous, active-high
//  restore_req  in   1                request a restore; sampled only while busy=0
//  skip_mask    in   NUM_REGS         bit i=1: do not write reg i; sampled with restore_req
//  backup_seen  in   1                high in any cycle the stack performs a backup
//  fbs_restore  out  1                restore strobe to stack, exactly 1 cycle per accepted req
//  fbs_data     in   REG_W*NUM_REGS   snapshot from stack
//  busy         out  1                sequence in progress
//  done         out  1                1-cycle pulse when sequence completes
//  underflow    out  1                1-cycle pulse: restore_req rejected, depth==0
//  overflow     out  1                sticky: backup_seen while depth at max
//  rf_wen       out  1                register-file write enable
//  rf_waddr     out  $clog2(NUM_REGS) register-file write address
//  rf_wdata     out  REG_W            register-file write data
//  depth        out  DEPTH_W          current stack depth
// BEHAVIOUR
//  Reset: state IDLE; depth=0; all outputs 0; snapshot and skip latches cleared.
//  Reset is honoured in any state. A sequence in flight is abandoned without a done pulse.
//  States: IDLE -> ISSUE -> WAIT -> WRITE -> DONE -> IDLE.
//  IDLE: accept when restore_req=1 && backup_seen=0 && depth!=0.
//    On accept, latch skip_mask and go to ISSUE.
//    If restore_req=1 && depth==0: pulse underflow next cycle and stay IDLE.
//    If restore_req=1 && backup_seen=1: do not accept; the requester holds the request.
//  ISSUE (1 cycle): fbs_restore=1, busy=1, depth decrements at the end of this cycle.
//  WAIT (READ_LAT cycles): busy=1. On the last WAIT edge, fbs_data is captured.
//  WRITE (NUM_REGS cycles, index i=0..NUM_REGS-1):
//    rf_waddr=i, rf_wdata=snap[i*REG_W +: REG_W], rf_wen=~skip[i].
//    Skipped registers still consume their cycle, so latency is fixed.
//  DONE (1 cycle): done=1, busy=0. Next state is IDLE.
//  busy=1 in ISSUE, WAIT and WRITE. rf_wen=0 outside WRITE.
//  Latency: accept edge -> done high = 1+READ_LAT+NUM_REGS+1 cycles (19 at defaults).
//  depth: +1 per backup_seen cycle, in every state.
//    At all-ones it holds and sets overflow (cleared only by reset).
//    An ISSUE cycle coinciding with backup_seen leaves depth unchanged (+1-1).
//  restore_req while busy or in DONE: ignored; not queued.
//  skip_mask changes after accept have no effect on the current sequence.
//  fbs_data is not captured except on the last WAIT edge.
// TESTING
//  1 Reset, restore_req=1 -> underflow pulse next cycle, fbs_restore never 1, depth=0.
//  2 3x backup_seen, then restore_req with snapshot regs i=16'h1000+i, skip=0
//    -> fbs_restore 1 cycle, depth 3->2, 16 writes addr 0..15 data 1000..100F,
//    done at accept+19.
//  3 As 2 with skip_mask=16'h0003 -> rf_wen low for addr 0,1, done still at accept+19.
//  4 restore_req and backup_seen in same IDLE cycle -> not accepted; held req accepted next cycle.
//  5 backup_seen during ISSUE cycle -> depth unchanged; during WRITE -> depth+1, writes unaffected.
//  6 reset asserted mid-WRITE (i=7) -> next cycle rf_wen=0, busy=0, depth=0, no done pulse.

Source files
------------

// File: rtl/freg_restore_seq_if.sv
// Bundles the restore sequencer's stack, register-file and status signals.
// The master modport is the sequencer; the slave modport is the surrounding stack/RF side.
interface freg_restore_seq_if #(
  parameter int REG_W    = 16,
  parameter int NUM_REGS = 16,
  parameter int DEPTH_W  = 16
);
  logic                        restore_req;
  logic [NUM_REGS-1:0]         skip_mask;
  logic                        backup_seen;
  logic                        fbs_restore;
  logic [REG_W*NUM_REGS-1:0]   fbs_data;
  logic                        busy;
  logic                        done;
  logic                        underflow;
  logic                        overflow;
  logic                        rf_wen;
  logic [$clog2(NUM_REGS)-1:0] rf_waddr;
  logic [REG_W-1:0]            rf_wdata;
  logic [DEPTH_W-1:0]          depth;

  modport master (
    input  restore_req, skip_mask, backup_seen, fbs_data,
    output fbs_restore, busy, done, underflow, overflow,
    output rf_wen, rf_waddr, rf_wdata, depth
  );

  modport slave (
    output restore_req, skip_mask, backup_seen, fbs_data,
    input  fbs_restore, busy, done, underflow, overflow,
    input  rf_wen, rf_waddr, rf_wdata, depth
  );
endinterface

// File: rtl/freg_restore_seq.sv
// Restore sequencer: strobes the backup stack, captures the returned snapshot and writes it
// back one register per cycle; tracks stack depth and rejects restores on an empty stack.
module freg_restore_seq #(
  parameter int REG_W    = 16,
  parameter int NUM_REGS = 16,
  parameter int READ_LAT = 1,
  parameter int DEPTH_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  freg_restore_seq_if.master bus
);
  localparam int AW    = $clog2(NUM_REGS);
  localparam int CMAX  = (READ_LAT > NUM_REGS) ? READ_LAT : NUM_REGS;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int SNAPW = REG_W * NUM_REGS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REGS-1:0] skip_q, skip_d;
  logic [SNAPW-1:0]    snap_q, snap_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                underflow_q, underflow_d;
  logic                overflow_q, overflow_d;
  logic [AW-1:0]       idx;

  assign idx = cnt_q[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      skip_q      <= '0;
      snap_q      <= '0;
      depth_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      snap_q      <= snap_d;
      depth_q     <= depth_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    skip_d      = skip_q;
    snap_d      = snap_q;
    underflow_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.restore_req) begin
          if (depth_q == '0) begin
            underflow_d = 1'b1;
          end else if (!bus.backup_seen) begin
            // A same-cycle backup would change the top of stack under us; requester holds.
            skip_d  = bus.skip_mask;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CW'(READ_LAT - 1)) begin
          snap_d  = bus.fbs_data;
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (cnt_q == CW'(NUM_REGS - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Backup and ISSUE in the same cycle cancel; saturate at all-ones and flag overflow.
  always_comb begin
    depth_d    = depth_q;
    overflow_d = overflow_q;
    if (bus.backup_seen && (state_q != S_ISSUE)) begin
      if (&depth_q) begin
        overflow_d = 1'b1;
      end else begin
        depth_d = depth_q + 1'b1;
      end
    end else if (!bus.backup_seen && (state_q == S_ISSUE)) begin
      depth_d = depth_q - 1'b1;
    end
  end

  always_comb begin
    bus.fbs_restore = (state_q == S_ISSUE);
    bus.busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WRITE);
    bus.done        = (state_q == S_DONE);
    bus.underflow   = underflow_q;
    bus.overflow    = overflow_q;
    bus.depth       = depth_q;
    bus.rf_wen      = 1'b0;
    bus.rf_waddr    = '0;
    bus.rf_wdata    = '0;
    if (state_q == S_WRITE) begin
      bus.rf_wen   = ~skip_q[idx];
      bus.rf_waddr = idx;
      bus.rf_wdata = snap_q[idx*REG_W +: REG_W];
    end
  end
endmodule
